// File: rtl/lfsr_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Sequencer for a Fibonacci LFSR. Loads a seed through the
//               LFSR's rst/seed pins, runs one full period, measures it,
//               flags lockup/timeout and buffers LFSR values into a
//               one-entry valid/ready register with drop counting.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
  parameter int                WIDTH        = 5,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                MAX_PERIOD   = 31,
  parameter int                CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] seed_in,
  output logic             lfsr_rst,
  output logic [WIDTH-1:0] lfsr_seed,
  input  logic [WIDTH-1:0] lfsr_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_data,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             zero_seed,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] DROP_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // lfsr_seed doubles as the captured seed; it only changes on an accepted start.
  logic start_ok;
  logic run_stop;
  logic run_lock;
  logic run_match;
  logic run_tout;
  logic run_load;
  logic accept;

  // Decode the RUN-cycle outcome in priority order: stop, lockup, match, timeout, load.
  always_comb begin
    start_ok  = 1'b0;
    run_stop  = 1'b0;
    run_lock  = 1'b0;
    run_match = 1'b0;
    run_tout  = 1'b0;
    run_load  = 1'b0;
    accept    = rnd_valid & rnd_ready;
    if (state == IDLE) begin
      start_ok = start;
    end
    if (state == RUN) begin
      if (stop) begin
        run_stop = 1'b1;
      end else if (lfsr_data == '0) begin
        run_lock = 1'b1;
      end else if ((cnt != '0) && (lfsr_data == lfsr_seed)) begin
        run_match = 1'b1;
      end else if (cnt == MAX_CNT) begin
        run_tout = 1'b1;
      end else begin
        run_load = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered control and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lfsr_rst     <= 1'b0;
      lfsr_seed    <= DEFAULT_SEED;
      busy         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      zero_seed    <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            lfsr_seed    <= (seed_in == '0) ? DEFAULT_SEED : seed_in;
            zero_seed    <= (seed_in == '0);
            period_valid <= 1'b0;
            err          <= 1'b0;
            cnt          <= '0;
            lfsr_rst     <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          // The LFSR captures lfsr_seed on the edge that ends this cycle.
          lfsr_rst <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (run_stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (run_lock || run_tout) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (run_match) begin
            period       <= cnt;
            period_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          lfsr_rst <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // One-entry output buffer: load on plain RUN cycles, count drops when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (start_ok) begin
        drop_cnt <= '0;
      end
      if (run_load) begin
        if (!rnd_valid || accept) begin
          rnd_data  <= lfsr_data;
          rnd_valid <= 1'b1;
        end else if (drop_cnt != DROP_SAT) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end else if (accept) begin
        rnd_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
